secded2_128_enc: RTL and testbench

//  - SECDED encoder for 128-bit data words. Produces a 137-bit codeword: data, 8 Hamming check bits and 1 overall parity bit.
//  - Write-side partner of secded2_128_dec. Any codeword it emits decodes in secded2_128_dec to the original data with no error flags.
//  - Sits between the write-data source and storage/link. The datapath is a 2-stage pipeline with valid/ready on both sides and supports stalls.

---
 rtl/secded2_128_enc.sv | 125 ++++++++++++
 tb/tb_secded2_128_enc.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/secded2_128_enc.sv
// secded2_128_enc: SECDED encoder, 128 data bits -> 137-bit codeword.
// Code layout: [0:127] data, [128+k] Hamming check bit c_k, [136] overall even parity.
// Two-stage valid/ready pipeline: stage 1 holds the data and 16-bit-slice partial
// check XORs; stage 2 does the final reduction and parity and holds the output register.
// Optional build macro SECDED2_ENC_ERRINJ_EN adds i_inj_mask/i_inj_arm. An armed mask is
// captured with its word and XORed into the finished codeword.
module secded2_128_enc #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [0:127]     i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [0:136]     o_code,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [CNT_W-1:0] o_enc_count
`ifdef SECDED2_ENC_ERRINJ_EN
    ,
    input  logic [0:136]     i_inj_mask,
    input  logic             i_inj_arm
`endif
);

    // Hamming position of data bit idx. Start from its 1-based rank and skip
    // every power-of-two slot at or below the running position.
    function automatic logic [7:0] data_pos(input int idx);
        int r;
        r = idx + 1;
        for (int k = 0; k < 8; k++) begin
            if ((1 << k) <= r) r = r + 1;
        end
        return 8'(r);
    endfunction

    logic             s1_valid;
    logic [0:127]     s1_data;
    logic [7:0][7:0]  s1_part;     // [check bit k][16-bit data slice]
    logic [7:0][7:0]  part_n;
    logic             s2_valid;
    logic             s2_load;
    logic             in_xfer;
    logic [7:0]       chk;
    logic             par;
    logic [0:136]     code_n;
`ifdef SECDED2_ENC_ERRINJ_EN
    logic [0:136]     s1_mask;
`endif

    assign s2_load = enable & (~s2_valid | i_ready);
    assign o_ready = ~reset & enable & (~s1_valid | ~s2_valid | i_ready);
    assign in_xfer = i_valid & o_ready;
    assign o_valid = s2_valid;

    // Stage-1 partial XOR trees: one bit per (check bit, 16-bit data slice).
    always_comb begin
        logic [7:0] pos;
        part_n = '0;
        for (int s = 0; s < 8; s++) begin
            for (int b = 0; b < 16; b++) begin
                pos = data_pos(s * 16 + b);
                for (int k = 0; k < 8; k++) begin
                    if (pos[k]) part_n[k][s] = part_n[k][s] ^ i_data[s * 16 + b];
                end
            end
        end
    end

    // Stage-2 final reduction, overall parity and optional error-mask injection.
    always_comb begin
        for (int k = 0; k < 8; k++) chk[k] = ^s1_part[k];
        par = (^s1_data) ^ (^chk);
        code_n = '0;
        code_n[0:127] = s1_data;
        for (int k = 0; k < 8; k++) code_n[128 + k] = chk[k];
        code_n[136] = par;
`ifdef SECDED2_ENC_ERRINJ_EN
        code_n = code_n ^ s1_mask;
`endif
    end

    // Stage-1 register; data is captured only on a real transfer-in so idle X never enters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_part  <= '0;
`ifdef SECDED2_ENC_ERRINJ_EN
            s1_mask  <= '0;
`endif
        end else if (o_ready) begin
            s1_valid <= i_valid;
            if (in_xfer) begin
                s1_data <= i_data;
                s1_part <= part_n;
`ifdef SECDED2_ENC_ERRINJ_EN
                s1_mask <= i_inj_arm ? i_inj_mask : '0;
`endif
            end
        end
    end

    // Stage-2 / output register; holds during a downstream stall or while disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            o_code   <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) o_code <= code_n;
        end
    end

    // Delivered-codeword counter, wraps silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_enc_count <= '0;
        end else if (enable & s2_valid & i_ready) begin
            o_enc_count <= o_enc_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_secded2_128_enc.sv
// Bench for secded2_128_enc: reference encoder/decoder built from the Hamming
// position rule, a scoreboard of words in flight, and directed plus random steps.
module tb_secded2_128_enc;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             enable = 1'b1;
    logic [0:127]     i_data = '0;
    logic             i_valid = 1'b0;
    logic             o_ready;
    logic [0:136]     o_code;
    logic             o_valid;
    logic             i_ready = 1'b1;
    logic [CNT_W-1:0] o_enc_count;
`ifdef SECDED2_ENC_ERRINJ_EN
    logic [0:136]     i_inj_mask = '0;
    logic             i_inj_arm = 1'b0;
`endif

    secded2_128_enc #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
        .o_code(o_code), .o_valid(o_valid), .i_ready(i_ready),
        .o_enc_count(o_enc_count)
`ifdef SECDED2_ENC_ERRINJ_EN
        , .i_inj_mask(i_inj_mask), .i_inj_arm(i_inj_arm)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [0:127] d;
        logic [0:136] m;
    } item_t;

    item_t            q[$];
    logic [CNT_W-1:0] exp_count = '0;
    int               delivered = 0;
    int               n_assert = 0;
    int               n_fail = 0;

    task automatic chk(input string tag, input logic [136:0] obs, input logic [136:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference encoder: data fills non-power-of-two positions in order; the check
    // bits are the XOR of the positions of all set data bits.
    function automatic logic [0:136] ref_enc(input logic [0:127] d);
        logic [0:136] c;
        logic [7:0]   syn;
        int           j;
        c = '0; syn = '0; j = 0;
        for (int p = 1; p <= 136; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[j] = d[j];
                if (d[j]) syn = syn ^ 8'(p);
                j++;
            end
        end
        for (int k = 0; k < 8; k++) c[128 + k] = syn[k];
        c[136] = ^c[0:135];
        return c;
    endfunction

    // Reference decoder: st 0 = clean, 1 = single error corrected, 2 = double error.
    function automatic void ref_dec(input logic [0:136] c, output int st, output logic [0:127] d);
        int syn;
        int j;
        syn = 0; j = 0;
        for (int p = 1; p <= 136; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[j] = c[j];
                if (c[j]) syn = syn ^ p;
                j++;
            end
        end
        for (int k = 0; k < 8; k++) if (c[128 + k]) syn = syn ^ (1 << k);
        if (syn == 0 && !(^c)) st = 0;
        else if (^c) begin
            st = 1;
            j = 0;
            for (int p = 1; p <= 136; p++) begin
                if ((p & (p - 1)) != 0) begin
                    if (p == syn) d[j] = ~d[j];
                    j++;
                end
            end
        end else st = 2;
    endfunction

    // Scoreboard: predicts o_ready from occupancy, checks each delivered codeword and the counter.
    always @(negedge clk) begin
        item_t        it;
        int           st;
        logic [0:127] dd;
        if (reset) begin
            q.delete();
            exp_count = '0;
        end else begin
            chk("ready", 137'(o_ready), 137'(enable && (q.size() < 2 || i_ready)));
            chk("count", 137'(o_enc_count), 137'(exp_count));
            if (o_valid && i_ready && enable) begin
                n_assert++;
                assert (q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_out: observed code %h with no word in flight", o_code);
                end
                if (q.size() > 0) begin
                    it = q.pop_front();
                    chk("code", o_code, ref_enc(it.d) ^ it.m);
                    if (it.m == '0) begin
                        ref_dec(o_code, st, dd);
                        chk("dec_status", 137'(st), 137'(0));
                        chk("dec_data", 137'(dd), 137'(it.d));
                    end
                    exp_count = exp_count + CNT_W'(1);
                    delivered++;
                end
            end
            if (i_valid && o_ready && enable) begin
                it.d = i_data;
                it.m = '0;
`ifdef SECDED2_ENC_ERRINJ_EN
                if (i_inj_arm) it.m = i_inj_mask;
`endif
                q.push_back(it);
            end
        end
    end

    task automatic send_word(input logic [0:127] d);
        bit acc;
        bit done;
        done = 0;
        i_valid = 1'b1;
        i_data = d;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            acc = o_ready;
            @(posedge clk);
            #1;
            if (acc) done = 1;
        end
        chk("send_accepted", 137'(done), 137'(1));
        i_valid = 1'b0;
        i_data = 'x;
    endtask

    task automatic wait_valid();
        for (int n = 0; n < 20 && !o_valid; n++) begin
            @(posedge clk);
            #1;
        end
        chk("wait_valid", 137'(o_valid), 137'(1));
    endtask

    task automatic drain();
        for (int n = 0; n < 30 && q.size() != 0; n++) @(posedge clk);
        #1;
        chk("drain", 137'(q.size()), 137'(0));
    endtask

    function automatic logic [0:127] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [0:127] d;
        logic [0:136] e;
        logic [0:136] held;
        logic [0:127] words[3];
        int           accepted;
        int           w;
        int           d0;
        int           st;
        bit           acc;
        bit           have;

        // reset values
        #1 reset = 1'b1;
        #1;
        chk("rst_valid", 137'(o_valid), 137'(0));
        chk("rst_code", o_code, 137'(0));
        chk("rst_count", 137'(o_enc_count), 137'(0));
        chk("rst_ready", 137'(o_ready), 137'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // all-zero word: valid two clocks after transfer-in
        i_valid = 1'b1;
        i_data = '0;
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(posedge clk); #1;
        chk("zero_valid", 137'(o_valid), 137'(1));
        chk("zero_code", o_code, 137'(0));
        @(posedge clk); #1;
        chk("zero_count", 137'(o_enc_count), 137'(1));

        // single data bit 0 and bit 127
        d = '0; d[0] = 1'b1;
        send_word(d);
        wait_valid();
        e = '0; e[0] = 1'b1; e[128] = 1'b1; e[129] = 1'b1; e[136] = 1'b1;
        chk("bit0_code", o_code, e);
        d = '0; d[127] = 1'b1;
        send_word(d);
        wait_valid();
        e = '0; e[127] = 1'b1; e[131] = 1'b1; e[135] = 1'b1; e[136] = 1'b1;
        chk("bit127_code", o_code, e);
        drain();

        // back-to-back random stream
        d0 = delivered;
        for (int i = 0; i < 8; i++) begin
            i_valid = 1'b1;
            i_data = rnd128();
            @(posedge clk); #1;
            if (i >= 1) chk("stream_valid", 137'(o_valid), 137'(1));
        end
        i_valid = 1'b0;
        i_data = 'x;
        repeat (2) @(posedge clk);
        #1;
        chk("stream_delivered", 137'(delivered - d0), 137'(8));
        chk("stream_idle", 137'(o_valid), 137'(0));

        // stall: 3 words offered over 5 clocks with i_ready low
        for (int i = 0; i < 3; i++) words[i] = rnd128();
        i_ready = 1'b0;
        accepted = 0; w = 0; have = 0; held = '0;
        for (int c = 0; c < 5; c++) begin
            i_valid = 1'b1;
            i_data = words[w];
            @(negedge clk);
            acc = o_ready;
            @(posedge clk); #1;
            if (acc) begin
                accepted++;
                if (w < 2) w++;
            end
            if (o_valid) begin
                if (have) chk("stall_hold", o_code, held);
                else begin
                    held = o_code;
                    have = 1;
                end
            end
        end
        chk("stall_accepted", 137'(accepted), 137'(2));
        chk("stall_held_valid", 137'(o_valid), 137'(1));
        i_ready = 1'b1;
        send_word(words[2]);
        drain();

        // async reset with both stages full
        i_ready = 1'b0;
        send_word(rnd128());
        send_word(rnd128());
        chk("full_before_rst", 137'(o_valid), 137'(1));
        reset = 1'b1;
        #1;
        chk("midrst_valid", 137'(o_valid), 137'(0));
        chk("midrst_count", 137'(o_enc_count), 137'(0));
        chk("midrst_ready", 137'(o_ready), 137'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        i_ready = 1'b1;
        send_word(rnd128());
        chk("postrst_lat1", 137'(o_valid), 137'(0));
        @(posedge clk); #1;
        chk("postrst_valid", 137'(o_valid), 137'(1));
        drain();

        // random traffic with enable/ready toggling; X data whenever i_valid is low
        for (int c = 0; c < 80; c++) begin
            enable = ($urandom_range(0, 4) != 0);
            i_ready = ($urandom_range(0, 2) != 0);
            i_valid = $urandom_range(0, 1);
            i_data = i_valid ? rnd128() : 'x;
            @(posedge clk); #1;
        end
        enable = 1'b1;
        i_ready = 1'b1;
        i_valid = 1'b0;
        i_data = 'x;
        drain();

`ifdef SECDED2_ENC_ERRINJ_EN
        // injected single error: decoder corrects
        d = rnd128();
        i_inj_arm = 1'b1;
        i_inj_mask = '0; i_inj_mask[5] = 1'b1;
        send_word(d);
        i_inj_arm = 1'b0;
        wait_valid();
        ref_dec(o_code, st, words[0]);
        chk("inj1_status", 137'(st), 137'(1));
        chk("inj1_data", 137'(words[0]), 137'(d));
        drain();
        // injected double error: decoder flags uncorrectable
        d = rnd128();
        i_inj_arm = 1'b1;
        i_inj_mask = '0; i_inj_mask[5] = 1'b1; i_inj_mask[9] = 1'b1;
        send_word(d);
        i_inj_arm = 1'b0;
        wait_valid();
        ref_dec(o_code, st, words[0]);
        chk("inj2_status", 137'(st), 137'(2));
        drain();
`endif

        // counter wrap from all-ones
        @(posedge clk); #1;
        force dut.o_enc_count = '1;
        #1 release dut.o_enc_count;
        exp_count = '1;
        send_word(rnd128());
        wait_valid();
        @(posedge clk); #1;
        chk("count_wrap", 137'(o_enc_count), 137'(0));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
